// File: rtl/casr_pkg.sv
// casr_pkg: shared constants for the CASR random source and its packer.
//   CASR_WIDTH            - length of the cellular-automaton shift register
//   CASR_NTAPS            - random taps sampled per enabled cycle
//   CASR_PACKER_*         - default packer parameters
//   clog2_min1()          - $clog2 that never returns 0 (keeps vectors legal)
package casr_pkg;

  localparam int unsigned CASR_WIDTH             = 11;
  localparam int unsigned CASR_NTAPS             = 3;
  localparam int unsigned CASR_PACKER_WIDTH      = 12;
  localparam int unsigned CASR_PACKER_DEPTH      = 4;
  localparam int unsigned CASR_PACKER_RUN_LIMIT  = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/casr_packer_fifo.sv
// casr_packer_fifo: synchronous first-word-fall-through FIFO with a
// registered occupancy count.
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear_i      - synchronous flush, overrides push and pop
//   push_i       - write data_i (accepted if not full, or full with a pop)
//   pop_i        - discard the head word (ignored when empty)
//   data_o       - head word, 0 when empty
//   full_o       - count == DEPTH
//   empty_o      - count == 0
//   count_o      - registered occupancy
module casr_packer_fifo
  import casr_pkg::*;
#(
  parameter int unsigned WIDTH = CASR_PACKER_WIDTH,
  parameter int unsigned DEPTH = CASR_PACKER_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // Pop is evaluated first so a full FIFO can accept a push in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/casr_packer.sv
// casr_packer: samples the three CASR random taps on each enabled cycle,
// packs them MSB-first into WIDTH-bit words and queues the words in a
// first-word-fall-through FIFO behind a valid/ready interface.
//   clk, rst_n          - clock, asynchronous active-low reset
//   i_en                - sample {i_r2,i_r1,i_r0} this cycle
//   i_clear             - synchronous flush of packer, FIFO and flags
//   i_r0, i_r1, i_r2    - CASR random taps
//   o_data / o_valid    - FIFO head word (0 when empty) / FIFO non-empty
//   i_ready             - consumer accepts o_data
//   o_level             - FIFO occupancy
//   o_overflow          - sticky: a completed word was dropped
//   o_health_fail       - sticky: i_r0 stuck for RUN_LIMIT enabled samples
// Build option: define CASR_PACKER_HEALTH_EN to compile the r0 run-length
// health monitor; otherwise o_health_fail is tied to 0.
module casr_packer
  import casr_pkg::*;
#(
  parameter int unsigned WIDTH     = CASR_PACKER_WIDTH,
  parameter int unsigned DEPTH     = CASR_PACKER_DEPTH,
  parameter int unsigned RUN_LIMIT = CASR_PACKER_RUN_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic                       i_clear,
  input  logic                       i_r0,
  input  logic                       i_r1,
  input  logic                       i_r2,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic                       o_health_fail
);

  localparam int unsigned NW   = WIDTH / CASR_NTAPS;
  localparam int unsigned CNTW = clog2_min1(NW);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_shift;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             last_sample;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ovf_q, ovf_d;

  // Truncating cast keeps {acc[WIDTH-4:0], r2, r1, r0}; also legal for WIDTH == 3.
  assign acc_shift   = WIDTH'({acc_q, i_r2, i_r1, i_r0});
  assign last_sample = (cnt_q == CNTW'(NW - 1));
  assign push        = i_en && last_sample && !i_clear;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (i_en) begin
      acc_d = acc_shift;
      cnt_d = last_sample ? '0 : cnt_q + CNTW'(1);
    end
  end

  // A full FIFO always has o_valid high, so the word is dropped exactly
  // when no pop is offered alongside it.
  always_comb begin
    ovf_d = ovf_q;
    if (i_clear)                          ovf_d = 1'b0;
    else if (push && fifo_full && !i_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  casr_packer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (i_clear),
    .push_i  (push),
    .pop_i   (i_ready),
    .data_i  (acc_shift),
    .data_o  (o_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_level)
  );

  assign o_valid    = !fifo_empty;
  assign o_overflow = ovf_q;

`ifdef CASR_PACKER_HEALTH_EN
  localparam int unsigned RW = $clog2(RUN_LIMIT + 1);

  logic [RW-1:0] run_q, run_d;
  logic          prev_q, prev_d;
  logic          fail_q, fail_d;

  // run_q == 0 marks "no sample seen yet"; the run saturates at RUN_LIMIT.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    fail_d = fail_q;
    if (i_clear) begin
      run_d  = '0;
      prev_d = 1'b0;
      fail_d = 1'b0;
    end else if (i_en) begin
      prev_d = i_r0;
      if (run_q == '0 || i_r0 != prev_q) run_d = RW'(1);
      else if (run_q != RW'(RUN_LIMIT))  run_d = run_q + RW'(1);
      if (run_d == RW'(RUN_LIMIT))       fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
      fail_q <= fail_d;
    end
  end

  assign o_health_fail = fail_q;
`else
  assign o_health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_casr_packer.sv
// tb_casr_packer: directed scoreboard bench for casr_packer (WIDTH=12,
// DEPTH=4). Expected words are queued as stimulus completes them; a
// monitor on the falling edge pops and compares on every o_valid&&i_ready.
module tb_casr_packer;
  import casr_pkg::*;

  localparam int W  = 12;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);
`ifdef CASR_PACKER_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  // Pattern p repeated four times: p * 0x249.
  localparam logic [11:0] WV [8] = '{12'h000, 12'h249, 12'h492, 12'h6DB,
                                     12'h924, 12'hB6D, 12'hDB6, 12'hFFF};

  logic          clk;
  logic          rst_n;
  logic          i_en;
  logic          i_clear;
  logic          i_r0, i_r1, i_r2;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          i_ready;
  logic [LW-1:0] o_level;
  logic          o_overflow;
  logic          o_health_fail;

  int            errors = 0;
  int            checks = 0;
  logic [11:0]   exp_q [$];
  logic [11:0]   mon_exp;
  bit            mon_en = 1'b1;

  casr_packer #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RUN_LIMIT (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_clear       (i_clear),
    .i_r0          (i_r0),
    .i_r1          (i_r1),
    .i_r2          (i_r2),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_health_fail (o_health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && mon_en && o_valid && i_ready && !i_clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("word", {20'd0, o_data}, {20'd0, mon_exp});
      end
    end
  end

  task automatic step(input bit en, input logic [2:0] t, input bit rdy);
    i_en = en;
    {i_r2, i_r1, i_r0} = t;
    i_ready = rdy;
    @(posedge clk);
    #1;
    i_en    = 1'b0;
    i_ready = 1'b0;
  endtask

  task automatic word(input int p, input bit rdy);
    repeat (4) step(1'b1, 3'(p), rdy);
  endtask

  task automatic clear_step();
    i_clear = 1'b1;
    step(1'b1, 3'b111, 1'b1);
    i_clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_data"},   {20'd0, o_data}, 32'd0);
    chk({nm, "_valid"},  {31'd0, o_valid}, 32'd0);
    chk({nm, "_level"},  32'(o_level), 32'd0);
    chk({nm, "_ovf"},    {31'd0, o_overflow}, 32'd0);
    chk({nm, "_health"}, {31'd0, o_health_fail}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
    i_r0 = 1'b0; i_r1 = 1'b0; i_r2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // Pack pattern 101 x4 -> 0xB6D
    repeat (3) step(1'b1, 3'b101, 1'b0);
    chk("pack_valid_early", {31'd0, o_valid}, 32'd0);
    step(1'b1, 3'b101, 1'b0);
    exp_q.push_back(WV[5]);
    chk("pack_valid", {31'd0, o_valid}, 32'd1);
    chk("pack_data", {20'd0, o_data}, 32'hB6D);
    chk("pack_level", 32'(o_level), 32'd1);
    step(1'b0, 3'b000, 1'b1);
    chk("pack_drained", 32'(o_level), 32'd0);

    // Enable gaps with different taps on disabled cycles
    repeat (2) step(1'b1, 3'b101, 1'b0);
    repeat (3) step(1'b0, 3'b010, 1'b0);
    chk("gap_valid_hold", {31'd0, o_valid}, 32'd0);
    step(1'b1, 3'b101, 1'b0);
    chk("gap_valid_3rd", {31'd0, o_valid}, 32'd0);
    step(1'b1, 3'b101, 1'b0);
    exp_q.push_back(WV[5]);
    chk("gap_data", {20'd0, o_data}, 32'hB6D);
    step(1'b0, 3'b000, 1'b1);

    // Overflow: 5 words, 5th dropped
    word(1, 1'b0); exp_q.push_back(WV[1]);
    word(2, 1'b0); exp_q.push_back(WV[2]);
    word(3, 1'b0); exp_q.push_back(WV[3]);
    word(4, 1'b0); exp_q.push_back(WV[4]);
    chk("ovf_not_yet", {31'd0, o_overflow}, 32'd0);
    word(6, 1'b0);
    chk("ovf_level", 32'(o_level), 32'd4);
    chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
    chk("ovf_head", {20'd0, o_data}, 32'h249);
    repeat (4) step(1'b0, 3'b000, 1'b1);
    chk("ovf_drain_level", 32'(o_level), 32'd0);
    chk("ovf_drain_valid", {31'd0, o_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    clear_step();
    check_idle("clear1");

    // Full plus simultaneous pop
    word(7, 1'b0); exp_q.push_back(WV[7]);
    word(1, 1'b0); exp_q.push_back(WV[1]);
    word(2, 1'b0); exp_q.push_back(WV[2]);
    word(3, 1'b0); exp_q.push_back(WV[3]);
    chk("full_level", 32'(o_level), 32'd4);
    repeat (3) step(1'b1, 3'b101, 1'b0);
    step(1'b1, 3'b101, 1'b1);
    exp_q.push_back(WV[5]);
    chk("fullpop_level", 32'(o_level), 32'd4);
    chk("fullpop_ovf", {31'd0, o_overflow}, 32'd0);
    chk("fullpop_head", {20'd0, o_data}, 32'h249);
    repeat (4) step(1'b0, 3'b000, 1'b1);
    chk("fullpop_drained", 32'(o_level), 32'd0);

    // Empty plus simultaneous push/pop: push accepted
    repeat (3) step(1'b1, 3'b100, 1'b1);
    step(1'b1, 3'b100, 1'b1);
    exp_q.push_back(WV[4]);
    chk("emptypop_level", 32'(o_level), 32'd1);
    step(1'b0, 3'b000, 1'b1);

    // Clear mid-word with 2 words queued and a pop offered
    word(1, 1'b0);
    word(2, 1'b0);
    repeat (2) step(1'b1, 3'b111, 1'b0);
    clear_step();
    check_idle("clear2");
    repeat (3) step(1'b1, 3'b011, 1'b0);
    chk("clear_fresh_valid", {31'd0, o_valid}, 32'd0);
    step(1'b1, 3'b011, 1'b0);
    exp_q.push_back(WV[3]);
    chk("clear_fresh_data", {20'd0, o_data}, 32'h6DB);
    step(1'b0, 3'b000, 1'b1);

    // Reset pulsed mid-cycle, mid-word
    word(6, 1'b0);
    repeat (2) step(1'b1, 3'b101, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b1, 3'b010, 1'b0);
    chk("rst_no_spurious", {31'd0, o_valid}, 32'd0);
    step(1'b1, 3'b010, 1'b0);
    exp_q.push_back(WV[2]);
    chk("rst_fresh_data", {20'd0, o_data}, 32'h492);
    step(1'b0, 3'b000, 1'b1);
    chk("rst_drained", 32'(o_level), 32'd0);

    // Health: 31 stuck then toggle, then 32 stuck
    mon_en = 1'b0;
    clear_step();
    repeat (31) step(1'b1, 3'b000, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    chk("health_31_toggle", {31'd0, o_health_fail}, 32'd0);
    repeat (31) step(1'b1, 3'b000, 1'b1);
    chk("health_31", {31'd0, o_health_fail}, 32'd0);
    step(1'b1, 3'b000, 1'b1);
    chk("health_32", {31'd0, o_health_fail}, {31'd0, HEALTH});
    repeat (3) step(1'b0, 3'b001, 1'b1);
    chk("health_sticky", {31'd0, o_health_fail}, {31'd0, HEALTH});
    clear_step();
    chk("health_cleared", {31'd0, o_health_fail}, 32'd0);
    mon_en = 1'b1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
